// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter, port 0 fixed priority
// Port 1 gets a starvation boost and a bounded lock for atomic sequences.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        M0_REQ,
  input  logic [29:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  input  logic [3:0]  M0_WSTB,
  output logic        M0_GNT,
  output logic [31:0] M0_RDATA,
  output logic        M0_RVALID,
  input  logic        M1_REQ,
  input  logic [29:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  input  logic [3:0]  M1_WSTB,
  output logic        M1_GNT,
  output logic [31:0] M1_RDATA,
  output logic        M1_RVALID,
  input  logic        M1_LOCK,
  output logic [29:0] MEM_ADDR,
  output logic [31:0] MEM_DATAI,
  output logic        MEM_CE,
  output logic [3:0]  MEM_WSTB,
  input  logic [31:0] MEM_DATAO,
  output logic        STARVED
);

  localparam logic [3:0] WAIT_LIM  = 4'(MAX_WAIT);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t      state, state_next;
  logic [3:0]  wait_cnt;
  logic [7:0]  lock_cnt;
  logic        relock_block;
  logic        gnt0_raw, gnt1_raw;
  logic        gnt0, gnt1;
  logic        force_release;
  logic        lock_ok;

  assign STARVED       = (wait_cnt >= WAIT_LIM);
  assign force_release = (state == LOCKED) && (lock_cnt == LOCK_LAST);
  // After a forced release port 1 may only re-lock once port 0 has had its chance.
  assign lock_ok       = !relock_block || !M0_REQ;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (gnt1 && M1_LOCK && lock_ok) begin
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (!M1_LOCK || force_release) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    case (state)
      LOCKED: begin
        gnt1_raw = M1_REQ;
      end
      default: begin
        if (STARVED) begin
          gnt1_raw = M1_REQ;
          gnt0_raw = M0_REQ && !M1_REQ;
        end else begin
          gnt0_raw = M0_REQ;
          gnt1_raw = M1_REQ && !M0_REQ;
        end
      end
    endcase
  end

  // Grants are held low combinationally while reset is asserted.
  assign gnt0      = gnt0_raw && RST_N;
  assign gnt1      = gnt1_raw && RST_N;
  assign M0_GNT    = gnt0;
  assign M1_GNT    = gnt1;
  assign MEM_CE    = gnt0 || gnt1;
  assign MEM_ADDR  = gnt1 ? M1_ADDR  : M0_ADDR;
  assign MEM_DATAI = gnt1 ? M1_WDATA : M0_WDATA;
  assign MEM_WSTB  = gnt1 ? M1_WSTB  : (gnt0 ? M0_WSTB : 4'b0000);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= 4'd0;
    end else if (!M1_REQ || gnt1 || force_release) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_cnt <= 8'd0;
    end else if (state == IDLE) begin
      lock_cnt <= 8'd0;
    end else begin
      lock_cnt <= lock_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      relock_block <= 1'b0;
    end else if (force_release) begin
      relock_block <= 1'b1;
    end else if (state == IDLE && (!gnt1 || !M0_REQ)) begin
      relock_block <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      M0_RVALID <= 1'b0;
      M1_RVALID <= 1'b0;
      M0_RDATA  <= 32'd0;
      M1_RDATA  <= 32'd0;
    end else begin
      M0_RVALID <= gnt0;
      M1_RVALID <= gnt1;
      if (gnt0 && M0_WSTB == 4'b0000) begin
        M0_RDATA <= MEM_DATAO;
      end
      if (gnt1 && M1_WSTB == 4'b0000) begin
        M1_RDATA <= MEM_DATAO;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        M0_REQ, M1_REQ, M1_LOCK;
  logic [29:0] M0_ADDR, M1_ADDR;
  logic [31:0] M0_WDATA, M1_WDATA;
  logic [3:0]  M0_WSTB, M1_WSTB;
  logic        M0_GNT, M1_GNT, M0_RVALID, M1_RVALID;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic [29:0] MEM_ADDR;
  logic [31:0] MEM_DATAI, MEM_DATAO;
  logic        MEM_CE, STARVED;
  logic [3:0]  MEM_WSTB;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:15];

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MEM_CE) begin
      for (int b = 0; b < 4; b++) begin
        if (MEM_WSTB[b]) mem[MEM_ADDR[3:0]][8*b +: 8] <= MEM_DATAI[8*b +: 8];
      end
    end
  end

  assign MEM_DATAO = mem[MEM_ADDR[3:0]];

  dmem_arbiter #(.MAX_WAIT(4), .LOCK_MAX(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .M0_REQ(M0_REQ), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA), .M0_WSTB(M0_WSTB),
    .M0_GNT(M0_GNT), .M0_RDATA(M0_RDATA), .M0_RVALID(M0_RVALID),
    .M1_REQ(M1_REQ), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA), .M1_WSTB(M1_WSTB),
    .M1_GNT(M1_GNT), .M1_RDATA(M1_RDATA), .M1_RVALID(M1_RVALID),
    .M1_LOCK(M1_LOCK),
    .MEM_ADDR(MEM_ADDR), .MEM_DATAI(MEM_DATAI), .MEM_CE(MEM_CE),
    .MEM_WSTB(MEM_WSTB), .MEM_DATAO(MEM_DATAO), .STARVED(STARVED)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic m0_write(input logic [29:0] a, input logic [31:0] d);
    M0_REQ = 1'b1; M0_ADDR = a; M0_WDATA = d; M0_WSTB = 4'hF;
    #1;
    chk("pre_gnt", M0_GNT, 1);
    chk("pre_wstb", MEM_WSTB, 4'hF);
    step();
    M0_REQ = 1'b0; M0_WSTB = 4'h0;
  endtask

  initial begin
    RST_N = 1'b0;
    M0_REQ = 1'b1; M0_ADDR = 30'd5; M0_WDATA = 32'd0; M0_WSTB = 4'h0;
    M1_REQ = 1'b0; M1_ADDR = 30'd0; M1_WDATA = 32'd0; M1_WSTB = 4'h0; M1_LOCK = 1'b0;
    #2;
    chk("rst_m0_gnt", M0_GNT, 0);
    chk("rst_mem_ce", MEM_CE, 0);
    chk("rst_mem_wstb", MEM_WSTB, 0);
    chk("rst_m0_rvalid", M0_RVALID, 0);
    chk("rst_m1_rvalid", M1_RVALID, 0);
    chk("rst_m0_rdata", M0_RDATA, 0);
    chk("rst_m1_rdata", M1_RDATA, 0);
    chk("rst_starved", STARVED, 0);
    step();
    RST_N = 1'b1;
    M0_REQ = 1'b0;

    m0_write(30'd5, 32'hDEADBEEF);
    m0_write(30'd3, 32'h11223344);

    // single read on port 0
    M0_REQ = 1'b1; M0_ADDR = 30'd5; M0_WSTB = 4'h0;
    #1;
    chk("rd_gnt", M0_GNT, 1);
    chk("rd_mem_addr", MEM_ADDR, 5);
    chk("rd_mem_ce", MEM_CE, 1);
    step();
    M0_REQ = 1'b0;
    #1;
    chk("rd_rvalid", M0_RVALID, 1);
    chk("rd_rdata", M0_RDATA, 32'hDEADBEEF);
    chk("rd_m1_rvalid", M1_RVALID, 0);

    // byte write on port 1, then read back
    M1_REQ = 1'b1; M1_ADDR = 30'd3; M1_WDATA = 32'h000000AA; M1_WSTB = 4'b0001;
    #1;
    chk("bw_gnt", M1_GNT, 1);
    chk("bw_mem_wstb", MEM_WSTB, 4'b0001);
    chk("bw_mem_datai", MEM_DATAI, 32'h000000AA);
    step();
    M1_WSTB = 4'h0;
    chk("bw_rvalid", M1_RVALID, 1);
    chk("bw_rdata_hold", M1_RDATA, 0);
    #1;
    chk("bw_rd_gnt", M1_GNT, 1);
    step();
    M1_REQ = 1'b0;
    #1;
    chk("bw_readback", M1_RDATA, 32'h112233AA);
    step();

    // conflict: port 0 wins four times, then one boosted port 1 grant
    M0_REQ = 1'b1; M0_ADDR = 30'd5;
    M1_REQ = 1'b1; M1_ADDR = 30'd3;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("st_g0", M0_GNT, i != 4);
      chk("st_g1", M1_GNT, i == 4);
      chk("st_starved", STARVED, i == 4);
      if (i == 5) chk("st_m1_rvalid", M1_RVALID, 1);
      step();
    end
    M0_REQ = 1'b0; M1_REQ = 1'b0;
    step();

    // lock held too long: eight locked cycles, then forced release
    M1_REQ = 1'b1; M1_LOCK = 1'b1;
    #1;
    chk("lk_grant", M1_GNT, 1);
    step();
    M0_REQ = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("lk_g0", M0_GNT, i == 8);
      chk("lk_g1", M1_GNT, i != 8);
      step();
    end
    M0_REQ = 1'b0; M1_REQ = 1'b0; M1_LOCK = 1'b0;
    step();

    // voluntary unlock after three locked cycles
    M1_REQ = 1'b1; M1_LOCK = 1'b1;
    #1;
    chk("vu_grant", M1_GNT, 1);
    step();
    M0_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) M1_LOCK = 1'b0;
      #1;
      chk("vu_g0", M0_GNT, i == 3);
      chk("vu_g1", M1_GNT, i != 3);
      step();
    end
    M0_REQ = 1'b0; M1_REQ = 1'b0;
    step();

    // async reset between a grant and its response, with the boost active
    M0_REQ = 1'b1; M0_ADDR = 30'd5; M0_WSTB = 4'h0;
    M1_REQ = 1'b1; M1_ADDR = 30'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ar_g0", M0_GNT, 1);
      step();
    end
    chk("ar_pre_starved", STARVED, 1);
    chk("ar_pre_rvalid", M0_RVALID, 1);
    RST_N = 1'b0;
    #1;
    chk("ar_rvalid", M0_RVALID, 0);
    chk("ar_g0_rst", M0_GNT, 0);
    chk("ar_g1_rst", M1_GNT, 0);
    chk("ar_mem_ce", MEM_CE, 0);
    chk("ar_starved", STARVED, 0);
    step();
    RST_N = 1'b1;
    M1_REQ = 1'b0;
    #1;
    chk("ar_post_gnt", M0_GNT, 1);
    step();
    M0_REQ = 1'b0;
    #1;
    chk("ar_post_rvalid", M0_RVALID, 1);
    chk("ar_post_rdata", M0_RDATA, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
